program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the CPU's program/data memory load path; the CPU is the reader.
- Accepts a framed byte stream on a valid/ready interface and issues write strobes, addresses and data to instruction memory (256 x 8) and data memory (16 x 8).
- Holds the CPU in reset until a checksum-verified frame with the run flag set has been loaded.

Parameters:
- IMEM_AW, 8, instruction memory address width.
- DMEM_AW, 4, data memory address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, inter-byte timeout limit (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high at a clock edge.
- ins_write  output  1  instruction memory write strobe, one-cycle pulse.
- ins_addr  output  IMEM_AW  instruction memory write address.
- instruction_write_data  output  8  instruction byte.
- mem_write_tb  output  1  data memory write strobe, one-cycle pulse.
- access_addr_tb  output  DMEM_AW  data memory write address.
- mem_write_data_tb  output  8  data byte.
- cpu_hold  output  1  high keeps the CPU in reset.
- load_done  output  1  last frame passed its checksum.
- load_err  output  1  last frame failed (bad target, bad checksum or timeout).

Behaviour:
- Frame format: SYNC, TGT, ADDR, CNT, D[0..N-1], CHK.
  - TGT bit0: 0 = instruction memory, 1 = data memory.
  - TGT bit7: run flag.
  - TGT bits 6..1 must be 0.
  - N = CNT, except CNT = 0 means N = 256.
  - CHK = (TGT + ADDR + CNT + sum of D) mod 256.
- Reset values:
  - in_ready = 0, cpu_hold = 1.
  - All strobes, addresses, data outputs, load_done and load_err = 0.
  - State = IDLE.
- in_ready is 1 in every state after reset. All byte acceptance is a single cycle, so there is no back-pressure beyond reset.
- States:
  - IDLE: discard bytes that are not SYNC. On SYNC go to TGT, clear load_done and load_err, and set cpu_hold = 1. A reload therefore always re-holds the CPU.
  - TGT: latch the byte. If bits 6..1 are nonzero, set load_err = 1 and go to IDLE. Otherwise go to ADDR.
  - ADDR: latch the pointer, truncated to the target address width. Go to CNT.
  - CNT: latch the remaining count (9 bits), initialise the running sum, go to DATA.
  - DATA: on each accepted byte, register the data and address outputs and pulse the strobe for the selected target in the next cycle. Then increment the pointer modulo the target depth (wraps 255->0 or 15->0) and decrement the count. When the count reaches 0, go to CHK.
  - CHK: if the byte matches the sum, set load_done = 1, go to DONE, and clear cpu_hold one cycle later when the run flag was set. On mismatch, set load_err = 1, keep cpu_hold = 1, and go to IDLE.
  - DONE: behaves as IDLE.
- Write latency: one cycle from byte acceptance to strobe. Strobes for consecutive bytes may occur on back-to-back cycles.
- No rollback: bytes already written on an error remain in memory.
- SYNC is not special inside a frame; it is treated as ordinary data.
- Asynchronous reset mid-frame aborts immediately to the reset values; a partial write pulse is not completed.
- ins_write and mem_write_tb are never high in the same cycle.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: a counter clears on each accepted byte. If it reaches TIMEOUT_CYCLES while not in IDLE or DONE, set load_err = 1, keep cpu_hold = 1, and go to IDLE.
- Not defined: no counter; the loader waits indefinitely mid-frame.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, TGT, ADDR, CNT, DATA, CHK, DONE);
  - TGT_IMEM = 0, TGT_DMEM = 1;
  - RUN_BIT = 7;
  - default SYNC_BYTE.
- One sub-module is natural: loader_checksum (8-bit accumulator with clear and add-enable, plus a compare output).

Test Plan:
- Load IMEM: stream A5,80,00,03,11,22,33,E9 -> ins_write pulses at addresses 0,1,2 with data 11,22,33; load_done = 1; cpu_hold falls one cycle after the CHK byte.
- Load DMEM with wrap: stream A5,01,0E,03,AA,BB,CC,(checksum) with no run flag -> mem_write_tb pulses at addresses E,F,0; cpu_hold stays 1; load_done = 1.
- Bad checksum: the first frame with CHK = 00 -> 3 writes occur; load_err = 1; cpu_hold = 1; state returns to IDLE.
- Bad target, then junk bytes: A5,02 -> load_err = 1, no writes; subsequent non-A5 bytes are ignored.
- Reset mid-DATA: assert reset after 2 data bytes -> all outputs return to reset values immediately; a following valid frame loads correctly.
- (LOADER_TIMEOUT_EN) Stall for TIMEOUT_CYCLES after the ADDR byte -> load_err = 1 at cycle 1024; the next SYNC starts a new frame.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Frame states, target encodings and the default sync marker.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TGT,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;
    localparam int RUN_BIT = 7;
    localparam logic [7:0] DEF_SYNC = 8'hA5;

    // Target byte is legal only when its reserved bits 6..1 are clear.
    function automatic logic tgt_ok(input logic [7:0] b);
        return (b[6:1] == 6'd0);
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit frame checksum with clear, add-enable and compare.
// match compares the accumulated sum against the presented byte.
module loader_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] data,
    input  logic [7:0] cmp,
    output logic       match
);

    logic [7:0] sum;

    // Accumulate header and payload bytes modulo 256.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= 8'd0;
        end else if (clr) begin
            sum <= 8'd0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == cmp);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for instruction and data memories.
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 4,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               ins_write,
    output logic [IMEM_AW-1:0] ins_addr,
    output logic [7:0]         instruction_write_data,
    output logic               mem_write_tb,
    output logic [DMEM_AW-1:0] access_addr_tb,
    output logic [7:0]         mem_write_data_tb,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);

    state_t state, state_n;

    logic               accept;
    logic               tgt_dmem;
    logic               tgt_run;
    logic [IMEM_AW-1:0] ptr;
    logic [DMEM_AW-1:0] dptr_inc;
    logic [8:0]         cnt;
    logic               run_pend;
    logic               timeout;

    logic start, ld_tgt, ld_addr, ld_cnt;
    logic wr_fire, set_done, set_err;
    logic sum_clr, sum_add, sum_ok;

    assign accept   = in_valid & in_ready;
    assign dptr_inc = ptr[DMEM_AW-1:0] + DMEM_AW'(1);

    loader_checksum u_chk (
        .clk    (clk),
        .reset  (reset),
        .clr    (sum_clr),
        .add_en (sum_add),
        .data   (in_data),
        .cmp    (in_data),
        .match  (sum_ok)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          busy;

    assign busy = (state != S_IDLE) && (state != S_DONE);

    // Count idle cycles between accepted bytes while inside a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (accept || !busy) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout = busy && !accept &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Frame state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-byte control decode.
    always_comb begin
        state_n  = state;
        start    = 1'b0;
        ld_tgt   = 1'b0;
        ld_addr  = 1'b0;
        ld_cnt   = 1'b0;
        wr_fire  = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        sum_clr  = 1'b0;
        sum_add  = 1'b0;
        if (timeout) begin
            set_err = 1'b1;
            state_n = S_IDLE;
        end else if (accept) begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (in_data == SYNC_BYTE) begin
                        start   = 1'b1;
                        sum_clr = 1'b1;
                        state_n = S_TGT;
                    end
                end
                S_TGT: begin
                    if (tgt_ok(in_data)) begin
                        ld_tgt  = 1'b1;
                        sum_add = 1'b1;
                        state_n = S_ADDR;
                    end else begin
                        set_err = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_ADDR: begin
                    ld_addr = 1'b1;
                    sum_add = 1'b1;
                    state_n = S_CNT;
                end
                S_CNT: begin
                    ld_cnt  = 1'b1;
                    sum_add = 1'b1;
                    state_n = S_DATA;
                end
                S_DATA: begin
                    wr_fire = 1'b1;
                    sum_add = 1'b1;
                    if (cnt == 9'd1) begin
                        state_n = S_CHK;
                    end
                end
                S_CHK: begin
                    if (sum_ok) begin
                        set_done = 1'b1;
                        state_n  = S_DONE;
                    end else begin
                        set_err = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Datapath: header latches, write port, status and CPU hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready               <= 1'b0;
            tgt_dmem               <= TGT_IMEM;
            tgt_run                <= 1'b0;
            ptr                    <= '0;
            cnt                    <= '0;
            run_pend               <= 1'b0;
            ins_write              <= 1'b0;
            ins_addr               <= '0;
            instruction_write_data <= '0;
            mem_write_tb           <= 1'b0;
            access_addr_tb         <= '0;
            mem_write_data_tb      <= '0;
            cpu_hold               <= 1'b1;
            load_done              <= 1'b0;
            load_err               <= 1'b0;
        end else begin
            in_ready     <= 1'b1;
            ins_write    <= 1'b0;
            mem_write_tb <= 1'b0;
            run_pend     <= 1'b0;
            if (run_pend) begin
                cpu_hold <= 1'b0;
            end
            if (start) begin
                load_done <= 1'b0;
                load_err  <= 1'b0;
                cpu_hold  <= 1'b1;
            end
            if (ld_tgt) begin
                tgt_dmem <= in_data[0];
                tgt_run  <= in_data[RUN_BIT];
            end
            if (ld_addr) begin
                if (tgt_dmem == TGT_DMEM) begin
                    ptr <= IMEM_AW'(in_data[DMEM_AW-1:0]);
                end else begin
                    ptr <= IMEM_AW'(in_data);
                end
            end
            if (ld_cnt) begin
                cnt <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            end
            if (wr_fire) begin
                cnt <= cnt - 9'd1;
                if (tgt_dmem == TGT_DMEM) begin
                    mem_write_tb      <= 1'b1;
                    access_addr_tb    <= ptr[DMEM_AW-1:0];
                    mem_write_data_tb <= in_data;
                    ptr               <= IMEM_AW'(dptr_inc);
                end else begin
                    ins_write              <= 1'b1;
                    ins_addr               <= ptr;
                    instruction_write_data <= in_data;
                    ptr                    <= ptr + IMEM_AW'(1);
                end
            end
            if (set_done) begin
                load_done <= 1'b1;
                run_pend  <= tgt_run;
            end
            if (set_err) begin
                load_err <= 1'b1;
                cpu_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader with a frame-level model.
// Expected writes are queued by the driver and popped by a monitor.
module tb_program_loader;

    typedef logic [7:0] bytes_t[$];

    typedef struct {
        bit dmem;
        int addr;
        int data;
    } wr_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ins_write;
    logic [7:0] ins_addr;
    logic [7:0] instruction_write_data;
    logic       mem_write_tb;
    logic [3:0] access_addr_tb;
    logic [7:0] mem_write_data_tb;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  model_hold = 1'b1;

    program_loader dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .ins_write              (ins_write),
        .ins_addr               (ins_addr),
        .instruction_write_data (instruction_write_data),
        .mem_write_tb           (mem_write_tb),
        .access_addr_tb         (access_addr_tb),
        .mem_write_data_tb      (mem_write_data_tb),
        .cpu_hold               (cpu_hold),
        .load_done              (load_done),
        .load_err               (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (ins_write || mem_write_tb) begin
            if (ins_write && mem_write_tb) begin
                check("both_strobes", 1, 0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_write", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("wr_target", int'(mem_write_tb), int'(e.dmem));
                if (mem_write_tb) begin
                    check("dmem_addr", int'(access_addr_tb), e.addr);
                    check("dmem_data", int'(mem_write_data_tb), e.data);
                end else begin
                    check("imem_addr", int'(ins_addr), e.addr);
                    check("imem_data", int'(instruction_write_data), e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 16) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) check("in_ready_wait", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] junk();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    task automatic send_frame(input bit dmem, input bit run,
                              input logic [7:0] addr,
                              input logic [7:0] cnt,
                              input bytes_t d, input int force_chk);
        logic [7:0] tgt;
        logic [7:0] chk;
        int sum, n, depth, a;
        bit ok;
        tgt   = {run, 6'd0, dmem};
        n     = (cnt == 8'd0) ? 256 : int'(cnt);
        depth = dmem ? 16 : 256;
        a     = int'(addr) % depth;
        sum   = int'(tgt) + int'(addr) + int'(cnt);
        send_byte(8'hA5);
        model_hold = 1'b1;
        gap();
        send_byte(tgt);
        gap();
        send_byte(addr);
        gap();
        send_byte(cnt);
        for (int i = 0; i < n; i++) begin
            sum += int'(d[i]);
            exp_q.push_back('{dmem, (a + i) % depth, int'(d[i])});
            gap();
            send_byte(d[i]);
        end
        chk = (force_chk >= 0) ? 8'(force_chk) : 8'(sum % 256);
        ok  = (int'(chk) == sum % 256);
        gap();
        send_byte(chk);
        check("load_done", int'(load_done), int'(ok));
        check("load_err", int'(load_err), int'(!ok));
        check("hold_at_chk", int'(cpu_hold), 1);
        @(posedge clk);
        #1;
        model_hold = !(ok && run);
        check("hold_after", int'(cpu_hold), int'(model_hold));
    endtask

    initial begin
        bytes_t d;
        logic [7:0] t;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_hold", int'(cpu_hold), 1);
        check("rst_iw", int'(ins_write), 0);
        check("rst_mw", int'(mem_write_tb), 0);
        check("rst_done", int'(load_done), 0);
        check("rst_err", int'(load_err), 0);
        check("rst_iaddr", int'(ins_addr), 0);
        check("rst_daddr", int'(access_addr_tb), 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", int'(in_ready), 1);

        d = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b0, 1'b1, 8'h00, 8'h03, d, -1);

        d = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(1'b1, 1'b0, 8'h0E, 8'h03, d, -1);

        d = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b0, 1'b1, 8'h00, 8'h03, d, 0);

        send_byte(8'hA5);
        send_byte(8'h02);
        model_hold = 1'b1;
        check("badtgt_err", int'(load_err), 1);
        check("badtgt_done", int'(load_done), 0);
        repeat (6) send_byte(junk());
        check("junk_err", int'(load_err), 1);
        check("junk_hold", int'(cpu_hold), int'(model_hold));

        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h04);
        exp_q.push_back('{1'b0, 8'h40, 8'h5C});
        send_byte(8'h5C);
        exp_q.push_back('{1'b0, 8'h41, 8'hA5});
        send_byte(8'hA5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", int'(in_ready), 0);
        check("mid_rst_hold", int'(cpu_hold), 1);
        check("mid_rst_iw", int'(ins_write), 0);
        check("mid_rst_iaddr", int'(ins_addr), 0);
        check("mid_rst_idata", int'(instruction_write_data), 0);
        check("mid_rst_q", exp_q.size(), 0);
        #2 reset = 1'b1;
        model_hold = 1'b1;
        d = '{8'h01, 8'h02};
        send_frame(1'b0, 1'b1, 8'hFF, 8'h02, d, -1);

`ifdef LOADER_TIMEOUT_EN
        send_byte(8'hA5);
        send_byte(8'h80);
        send_byte(8'h10);
        model_hold = 1'b1;
        repeat (1023) @(posedge clk);
        #1;
        check("tmo_early", int'(load_err), 0);
        @(posedge clk);
        #1;
        check("tmo_err", int'(load_err), 1);
        check("tmo_hold", int'(cpu_hold), 1);
        d = '{8'h77};
        send_frame(1'b1, 1'b1, 8'h03, 8'h01, d, -1);
`endif

        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(0, 3)) send_byte(junk());
            if ($urandom_range(0, 9) == 0) begin
                t = 8'($urandom) & 8'h81;
                t = t | 8'($urandom_range(1, 63) << 1);
                send_byte(8'hA5);
                send_byte(t);
                model_hold = 1'b1;
                check("rnd_badtgt", int'(load_err), 1);
            end else begin
                n = (f == 10) ? 256 : $urandom_range(1, 6);
                d = {};
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 7) == 0) d.push_back(8'hA5);
                    else d.push_back(8'($urandom));
                end
                send_frame(1'($urandom), 1'($urandom), 8'($urandom),
                           8'(n % 256), d,
                           ($urandom_range(0, 4) == 0) ?
                               int'(8'($urandom)) : -1);
            end
            check("rnd_hold", int'(cpu_hold), int'(model_hold));
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
